// File: rtl/decode_pkg.sv
// Shared encodings for the instruction decode sequencer: opcode/op
// constants, FSM state and instruction class enumerations.
package decode_pkg;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_WR   = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_MOV_IMM = 3'd0,
    CLS_MOV_REG = 3'd1,
    CLS_ALU2    = 3'd2,
    CLS_CMP     = 3'd3,
    CLS_MVN     = 3'd4,
    CLS_ILLEGAL = 3'd5
  } cls_t;

  // Classes that read both Rn (operand A) and Rm (operand B).
  function automatic logic needs_two_reads(input cls_t c);
    return (c == CLS_ALU2) || (c == CLS_CMP);
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational field extraction, immediate sign extension and
// instruction classification for one 16-bit instruction word.
module decode_fields
  import decode_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       instr,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        shift,
  output logic [2:0]        rn,
  output logic [2:0]        rd,
  output logic [2:0]        rm,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output cls_t              cls
);

  assign opcode = instr[15:13];
  assign op     = instr[12:11];
  assign rn     = instr[10:8];
  assign rd     = instr[7:5];
  assign shift  = instr[4:3];
  assign rm     = instr[2:0];

  assign sximm5 = {{(DATA_W-5){instr[4]}}, instr[4:0]};
  assign sximm8 = {{(DATA_W-8){instr[7]}}, instr[7:0]};

  // Map opcode/op onto an instruction class; anything unlisted is illegal.
  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_MOV: begin
        case (op)
          OP_MOV_IMM: cls = CLS_MOV_IMM;
          OP_MOV_REG: cls = CLS_MOV_REG;
          default:    cls = CLS_ILLEGAL;
        endcase
      end
      OPC_ALU: begin
        case (op)
          OP_ADD:  cls = CLS_ALU2;
          OP_AND:  cls = CLS_ALU2;
          OP_CMP:  cls = CLS_CMP;
          OP_MVN:  cls = CLS_MVN;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/decode_sequencer.sv
// Handshaked instruction decoder: latches one instruction and steps the
// register-file read/write selects one micro-step per accepted cycle.
module decode_sequencer
  import decode_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int READ_PORTS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [15:0]       in_instr,
  output logic              in_ready,
  output logic              step_valid,
  input  logic              step_ready,
  output logic              rd_en,
  output logic [2:0]        rd_num,
  output logic              rd_slot,
  output logic              rd2_en,
  output logic [2:0]        rd2_num,
  output logic              wr_en,
  output logic [2:0]        wr_num,
  output logic              status_en,
  output logic [2:0]        opcode,
  output logic [1:0]        alu_op,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic              done,
  output logic              illegal
);

  localparam bit DUAL_PORT = (READ_PORTS == 2);

  state_t            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic              step_valid_q, step_valid_d;
  logic              rd_en_q, rd_en_d;
  logic [2:0]        rd_num_q, rd_num_d;
  logic              rd_slot_q, rd_slot_d;
  logic              rd2_en_q, rd2_en_d;
  logic [2:0]        rd2_num_q, rd2_num_d;
  logic              wr_en_q, wr_en_d;
  logic [2:0]        wr_num_q, wr_num_d;
  logic              status_en_q, status_en_d;
  logic              illegal_q, illegal_d;
  logic [2:0]        opcode_q, opcode_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [1:0]        shift_q, shift_d;
  logic [DATA_W-1:0] sximm5_q, sximm5_d;
  logic [DATA_W-1:0] sximm8_q, sximm8_d;

  logic              accept_s;
  logic              fire_s;
  logic [2:0]        f_opcode_s, f_rn_s, f_rd_s, f_rm_s;
  logic [1:0]        f_op_s, f_shift_s;
  logic [DATA_W-1:0] f_sximm5_s, f_sximm8_s;
  cls_t              f_cls_s;

  assign in_ready = (state_q == ST_IDLE) && !reset;
  assign accept_s = in_valid && in_ready;
  assign fire_s   = step_valid_q && step_ready;

  // Decode the instruction the register will hold next cycle, so the
  // registered step outputs line up with the state they belong to.
  decode_fields #(.DATA_W(DATA_W)) u_fields (
    .instr  (ir_d),
    .opcode (f_opcode_s),
    .op     (f_op_s),
    .shift  (f_shift_s),
    .rn     (f_rn_s),
    .rd     (f_rd_s),
    .rm     (f_rm_s),
    .sximm5 (f_sximm5_s),
    .sximm8 (f_sximm8_s),
    .cls    (f_cls_s)
  );

  // Next instruction register value and next FSM state.
  always_comb begin
    if (accept_s) begin
      ir_d = in_instr;
    end else begin
      ir_d = ir_q;
    end
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!accept_s) begin
          state_d = ST_IDLE;
        end else if (f_cls_s == CLS_ILLEGAL) begin
          state_d = ST_ERR;
        end else if (f_cls_s == CLS_MOV_IMM) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD1;
        end
      end
      ST_RD1: begin
        if (!fire_s) begin
          state_d = ST_RD1;
        end else if (needs_two_reads(f_cls_s) && !DUAL_PORT) begin
          state_d = ST_RD2;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_RD2: begin
        if (fire_s) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD2;
        end
      end
      ST_WR: begin
        if (fire_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Step outputs for the state being entered; fields simply follow ir_d.
  always_comb begin
    step_valid_d = 1'b0;
    rd_en_d      = 1'b0;
    rd_num_d     = 3'd0;
    rd_slot_d    = 1'b0;
    rd2_en_d     = 1'b0;
    rd2_num_d    = 3'd0;
    wr_en_d      = 1'b0;
    wr_num_d     = 3'd0;
    status_en_d  = 1'b0;
    illegal_d    = 1'b0;
    opcode_d     = f_opcode_s;
    alu_op_d     = f_op_s;
    shift_d      = f_shift_s;
    sximm5_d     = f_sximm5_s;
    sximm8_d     = f_sximm8_s;
    case (state_d)
      ST_RD1: begin
        step_valid_d = 1'b1;
        rd_en_d      = 1'b1;
        if (needs_two_reads(f_cls_s)) begin
          rd_num_d  = f_rn_s;
          rd_slot_d = 1'b0;
          if (DUAL_PORT) begin
            rd2_en_d  = 1'b1;
            rd2_num_d = f_rm_s;
          end else begin
            rd2_en_d  = 1'b0;
            rd2_num_d = 3'd0;
          end
        end else begin
          rd_num_d  = f_rm_s;
          rd_slot_d = 1'b1;
        end
      end
      ST_RD2: begin
        step_valid_d = 1'b1;
        rd_en_d      = 1'b1;
        rd_num_d     = f_rm_s;
        rd_slot_d    = 1'b1;
      end
      ST_WR: begin
        step_valid_d = 1'b1;
        case (f_cls_s)
          CLS_MOV_IMM: begin
            wr_en_d  = 1'b1;
            wr_num_d = f_rn_s;
          end
          CLS_CMP: status_en_d = 1'b1;
          default: begin
            wr_en_d  = 1'b1;
            wr_num_d = f_rd_s;
          end
        endcase
      end
      ST_ERR:  illegal_d = 1'b1;
      default: step_valid_d = 1'b0;
    endcase
  end

  // State, instruction and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ir_q         <= 16'h0000;
      step_valid_q <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_num_q     <= 3'd0;
      rd_slot_q    <= 1'b0;
      rd2_en_q     <= 1'b0;
      rd2_num_q    <= 3'd0;
      wr_en_q      <= 1'b0;
      wr_num_q     <= 3'd0;
      status_en_q  <= 1'b0;
      illegal_q    <= 1'b0;
      opcode_q     <= 3'd0;
      alu_op_q     <= 2'd0;
      shift_q      <= 2'd0;
      sximm5_q     <= '0;
      sximm8_q     <= '0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      step_valid_q <= step_valid_d;
      rd_en_q      <= rd_en_d;
      rd_num_q     <= rd_num_d;
      rd_slot_q    <= rd_slot_d;
      rd2_en_q     <= rd2_en_d;
      rd2_num_q    <= rd2_num_d;
      wr_en_q      <= wr_en_d;
      wr_num_q     <= wr_num_d;
      status_en_q  <= status_en_d;
      illegal_q    <= illegal_d;
      opcode_q     <= opcode_d;
      alu_op_q     <= alu_op_d;
      shift_q      <= shift_d;
      sximm5_q     <= sximm5_d;
      sximm8_q     <= sximm8_d;
    end
  end

  // done marks the WR step being consumed; suppressed while in reset.
  assign done       = fire_s && (state_q == ST_WR) && !reset;
  assign step_valid = step_valid_q;
  assign rd_en      = rd_en_q;
  assign rd_num     = rd_num_q;
  assign rd_slot    = rd_slot_q;
  assign rd2_en     = rd2_en_q;
  assign rd2_num    = rd2_num_q;
  assign wr_en      = wr_en_q;
  assign wr_num     = wr_num_q;
  assign status_en  = status_en_q;
  assign illegal    = illegal_q;
  assign opcode     = opcode_q;
  assign alu_op     = alu_op_q;
  assign shift      = shift_q;
  assign sximm5     = sximm5_q;
  assign sximm8     = sximm8_q;

endmodule
